// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch address generator with branch/flush redirect.
// Ports: clk, rst (async active-low); stall, flush, exc_pc, branch_flag,
//   branch_addr in; pc, rom_en, fetch_adel out.
// Optional macro PC_GEN_ALIGN_CHECK_EN: flag misaligned fetch addresses
//   through fetch_adel instead of silently clearing the low two bits.
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] exc_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_addr,
   output logic [31:0] pc,
   output logic        rom_en,
   output logic        fetch_adel
);

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        pend_v;
   logic [31:0] pend_addr;
   logic        adel_q;
   logic [31:0] tgt;
   logic [31:0] tgt_ld;
   logic        adel_set;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // IDLE lasts exactly one edge after reset release.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rom_en = (state == FETCH) && !adel_q;
   end

   // Redirect priority: flush, pending branch, live branch, sequential.
   always_comb begin
      if (flush) begin
         tgt = exc_pc;
      end else if (pend_v) begin
         tgt = pend_addr;
      end else if (branch_flag) begin
         tgt = branch_addr;
      end else begin
         tgt = pc + 32'd4;
      end
   end

`ifdef PC_GEN_ALIGN_CHECK_EN
   assign tgt_ld   = tgt;
   assign adel_set = |tgt[1:0];
`else
   assign tgt_ld   = tgt & ~32'd3;
   assign adel_set = 1'b0;
`endif

   assign fetch_adel = adel_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_PC;
         pend_v    <= 1'b0;
         pend_addr <= 32'd0;
         adel_q    <= 1'b0;
      end else if (state == FETCH) begin
         if (flush) begin
            pc     <= tgt_ld;
            pend_v <= 1'b0;
            adel_q <= 1'b0;
         end else if (!adel_q) begin
            if (stall) begin
               // Remember a branch resolved while fetch is frozen.
               if (branch_flag) begin
                  pend_v    <= 1'b1;
                  pend_addr <= branch_addr;
               end
            end else begin
               pc     <= tgt_ld;
               pend_v <= 1'b0;
               adel_q <= adel_set;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a
// cycle-level behavioural model of the fetch address sequence.
module tb_pc_gen;

   localparam logic [31:0] RPC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] exc_pc = 32'd0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_addr = 32'd0;
   logic [31:0] pc;
   logic        rom_en;
   logic        fetch_adel;

   int checks = 0;
   int failures = 0;

   // Model: fetching started?, misaligned-hold flag, address, pending queue.
   bit          m_fetch;
   bit          m_adel;
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];

   pc_gen #(.RESET_PC(RPC)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush),
      .exc_pc(exc_pc),
      .branch_flag(branch_flag),
      .branch_addr(branch_addr),
      .pc(pc),
      .rom_en(rom_en),
      .fetch_adel(fetch_adel)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_fetch = 1'b0;
      m_adel  = 1'b0;
      m_pc    = RPC;
      m_pend.delete();
   endtask

   task automatic model_load(input logic [31:0] a, input bit chk);
`ifdef PC_GEN_ALIGN_CHECK_EN
      m_pc   = a;
      m_adel = chk && (a % 4 != 0);
`else
      m_pc   = a - (a % 4);
      m_adel = 1'b0;
`endif
   endtask

   task automatic model_edge();
      logic [31:0] a;
      if (!m_fetch) begin
         m_fetch = 1'b1;
      end else if (flush) begin
         model_load(exc_pc, 1'b0);
         m_pend.delete();
      end else if (m_adel) begin
         m_adel = 1'b1;
      end else if (stall) begin
         if (branch_flag) begin
            m_pend.delete();
            m_pend.push_back(branch_addr);
         end
      end else begin
         if (m_pend.size() != 0) a = m_pend.pop_front();
         else if (branch_flag) a = branch_addr;
         else a = m_pc + 32'd4;
         model_load(a, 1'b1);
      end
   endtask

   // Inputs change only at negedge; outputs are checked there too.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (pc !== RPC || rom_en !== 1'b0 || fetch_adel !== 1'b0) begin
         failures++;
         $display("FAIL reset got pc=%h en=%b adel=%b exp pc=%h en=0 adel=0",
                  pc, rom_en, fetch_adel, RPC);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (pc !== RPC || rom_en !== 1'b0) begin
         failures++;
         $display("FAIL release_c1 got pc=%h en=%b exp pc=%h en=0",
                  pc, rom_en, RPC);
      end
      step();
      checks++;
      if (pc !== RPC || rom_en !== 1'b1) begin
         failures++;
         $display("FAIL release_c2 got pc=%h en=%b exp pc=%h en=1",
                  pc, rom_en, RPC);
      end
      step();
      checks++;
      if (pc !== 32'hbfc00004) begin
         failures++;
         $display("FAIL release_c3 got pc=%h exp pc=bfc00004", pc);
      end
   endtask

   task automatic test_branch();
      step();
      step();
      step();
      checks++;
      if (pc !== 32'hbfc00010) begin
         failures++;
         $display("FAIL seq_pc got pc=%h exp pc=bfc00010", pc);
      end
      branch_flag = 1'b1;
      branch_addr = 32'hbfc00100;
      step();
      branch_flag = 1'b0;
      checks++;
      if (pc !== 32'hbfc00100) begin
         failures++;
         $display("FAIL branch_tgt got pc=%h exp pc=bfc00100", pc);
      end
      step();
      checks++;
      if (pc !== 32'hbfc00104) begin
         failures++;
         $display("FAIL branch_seq got pc=%h exp pc=bfc00104", pc);
      end
   endtask

   task automatic test_stall_branch();
      stall = 1'b1;
      branch_flag = 1'b1;
      branch_addr = 32'h80000040;
      for (int i = 0; i < 3; i++) begin
         step();
         branch_flag = 1'b0;
         checks++;
         if (pc !== 32'hbfc00104 || rom_en !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold%0d got pc=%h en=%b exp pc=bfc00104 en=1",
                     i, pc, rom_en);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if (pc !== 32'h80000040) begin
         failures++;
         $display("FAIL stall_pend got pc=%h exp pc=80000040", pc);
      end
      step();
      checks++;
      if (pc !== 32'h80000044) begin
         failures++;
         $display("FAIL pend_clear got pc=%h exp pc=80000044", pc);
      end
   endtask

   task automatic test_priority();
      stall = 1'b1;
      branch_flag = 1'b1;
      branch_addr = 32'h80001000;
      step();
      flush = 1'b1;
      exc_pc = 32'hbfc00380;
      branch_addr = 32'h80002000;
      step();
      flush = 1'b0;
      stall = 1'b0;
      branch_flag = 1'b0;
      checks++;
      if (pc !== 32'hbfc00380) begin
         failures++;
         $display("FAIL flush_prio got pc=%h exp pc=bfc00380", pc);
      end
      step();
      checks++;
      if (pc !== 32'hbfc00384) begin
         failures++;
         $display("FAIL flush_pclr got pc=%h exp pc=bfc00384", pc);
      end
   endtask

   task automatic test_wrap();
      branch_flag = 1'b1;
      branch_addr = 32'hfffffffc;
      step();
      branch_flag = 1'b0;
      step();
      checks++;
      if (pc !== 32'h00000000) begin
         failures++;
         $display("FAIL wrap got pc=%h exp pc=00000000", pc);
      end
      step();
      checks++;
      if (pc !== 32'h00000004) begin
         failures++;
         $display("FAIL wrap_seq got pc=%h exp pc=00000004", pc);
      end
   endtask

   task automatic test_align();
      branch_flag = 1'b1;
      branch_addr = 32'h80000042;
      step();
      branch_flag = 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pc !== 32'h80000042 || fetch_adel !== 1'b1 || rom_en !== 1'b0) begin
            failures++;
            $display("FAIL adel_hold%0d got pc=%h adel=%b en=%b exp 80000042 1 0",
                     i, pc, fetch_adel, rom_en);
         end
         step();
      end
      flush = 1'b1;
      exc_pc = 32'hbfc00380;
      step();
      flush = 1'b0;
      checks++;
      if (pc !== 32'hbfc00380 || fetch_adel !== 1'b0 || rom_en !== 1'b1) begin
         failures++;
         $display("FAIL adel_flush got pc=%h adel=%b en=%b exp bfc00380 0 1",
                  pc, fetch_adel, rom_en);
      end
`else
      checks++;
      if (pc !== 32'h80000040 || fetch_adel !== 1'b0 || rom_en !== 1'b1) begin
         failures++;
         $display("FAIL align_mask got pc=%h adel=%b en=%b exp 80000040 0 1",
                  pc, fetch_adel, rom_en);
      end
      step();
      checks++;
      if (pc !== 32'h80000044) begin
         failures++;
         $display("FAIL align_seq got pc=%h exp pc=80000044", pc);
      end
`endif
   endtask

   task automatic test_reset_midop();
      stall = 1'b1;
      branch_flag = 1'b1;
      branch_addr = 32'h80000800;
      step();
      branch_flag = 1'b0;
      stall = 1'b0;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (pc !== RPC || rom_en !== 1'b0 || fetch_adel !== 1'b0) begin
         failures++;
         $display("FAIL async_rst got pc=%h en=%b adel=%b exp %h 0 0",
                  pc, rom_en, fetch_adel, RPC);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      checks++;
      if (pc !== RPC || rom_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_restart got pc=%h en=%b exp %h 1", pc, rom_en, RPC);
      end
      step();
      checks++;
      if (pc !== RPC + 32'd4) begin
         failures++;
         $display("FAIL rst_nopend got pc=%h exp %h", pc, RPC + 32'd4);
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom % 4) == 0;
         flush = ($urandom % 10) == 0;
         branch_flag = ($urandom % 3) == 0;
         r = $urandom;
         if (($urandom % 4) != 0) r = r - (r % 4);
         branch_addr = r;
         r = $urandom;
         exc_pc = r - (r % 4);
         step();
         checks++;
         if (pc !== m_pc || rom_en !== (m_fetch && !m_adel) ||
             fetch_adel !== m_adel) begin
            failures++;
            $display("FAIL rand%0d got pc=%h en=%b adel=%b exp pc=%h en=%b adel=%b",
                     i, pc, rom_en, fetch_adel, m_pc, m_fetch && !m_adel, m_adel);
         end
      end
      stall = 1'b0;
      flush = 1'b0;
      branch_flag = 1'b0;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall_branch();
      test_priority();
      test_wrap();
      test_align();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'hbfc00000, fetch address loaded at reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port stall  input  1  IF-stage hold request from pipeline control.
REQ-005 SHALL provide port flush  input  1  exception/eret redirect request.
REQ-006 SHALL provide port exc_pc  input  32  flush target address.
REQ-007 SHALL provide port branch_flag  input  1  taken-branch/jump request from the ID-stage branch resolver.
REQ-008 SHALL provide port branch_addr  input  32  branch/jump target, valid when branch_flag=1.
REQ-009 SHALL provide port pc  output  32  current fetch address, also the instruction ROM address.
REQ-010 SHALL provide port rom_en  output  1  instruction ROM read enable.
REQ-011 SHALL provide port fetch_adel  output  1  misaligned fetch address flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE and FETCH; IDLE -> FETCH on the first clk edge with rst high; FETCH is left only by reset.
REQ-013 SHALL hold rom_en=0 in IDLE and pc=RESET_PC; first fetch (rom_en=1, pc=RESET_PC) occurs one cycle after reset release.
REQ-014 SHALL in FETCH with stall=0 load pc with next-PC by priority: flush -> exc_pc; else pending valid -> pending addr; else branch_flag -> branch_addr; else pc+4.
REQ-015 SHALL compute pc+4 modulo 2^32 (32'hfffffffc -> 32'h00000000), no carry out.
REQ-016 SHALL hold pc and keep rom_en=1 while stall=1 and flush=0.
REQ-017 SHALL, when branch_flag=1 during stall=1 and flush=0, capture branch_addr into a one-entry pending register and set pending valid; a later branch_flag under the same stall overwrites it.
REQ-018 SHALL clear pending valid in the cycle the pending address is loaded into pc.
REQ-019 SHALL, when pending valid and branch_flag=1 coincide with stall=0, load the pending address and ignore branch_flag.
REQ-020 SHALL give flush precedence regardless of stall: pc <= exc_pc next edge, pending valid cleared, branch_flag ignored that cycle.
REQ-021 SHALL apply a redirect with one-cycle latency: target appears on pc the cycle after the qualifying request.
REQ-022 SHALL treat flush or branch_flag in IDLE as ignored; pc stays RESET_PC.

Reset
REQ-023 SHALL on rst=0 immediately force pc=RESET_PC, rom_en=0, fetch_adel=0, pending valid=0, pending addr=0, state IDLE, independent of clk.
REQ-024 SHALL, on reset asserted mid-operation, discard any pending redirect and restart per REQ-013.

Configuration
REQ-025 SHALL use macro PC_GEN_ALIGN_CHECK_EN.
REQ-026 SHALL with PC_GEN_ALIGN_CHECK_EN defined: load the selected next-PC unmodified; if its bits [1:0]!=0, set fetch_adel=1 with that pc and drive rom_en=0 while fetch_adel=1; pc holds until flush, which loads exc_pc and clears fetch_adel.
REQ-027 SHALL without PC_GEN_ALIGN_CHECK_EN: force bits [1:0] of every loaded target to 2'b00 and tie fetch_adel to 0.

Verification
REQ-028 SHALL check reset release: rst low->high, no other input -> cycle 1 pc=bfc00000 rom_en=0; cycle 2 rom_en=1; cycle 3 pc=bfc00004.
REQ-029 SHALL check branch: pc=bfc00010, branch_flag=1 branch_addr=bfc00100 one cycle -> next pc=bfc00100, then bfc00104.
REQ-030 SHALL check stalled branch: stall=1 for 3 cycles with branch_flag=1 addr=80000040 in cycle 1 only -> pc frozen, rom_en=1; first cycle after stall drops -> pc=80000040.
REQ-031 SHALL check priority: flush=1 exc_pc=bfc00380 with stall=1, branch_flag=1, pending valid -> next pc=bfc00380, pending cleared.
REQ-032 SHALL check wrap: pc=fffffffc, no requests -> next pc=00000000.
REQ-033 SHALL check alignment: branch_addr=80000042 -> with macro fetch_adel=1, rom_en=0, pc=80000042 until flush; without macro pc=80000040, fetch_adel=0.
